mq_iu_cu_elastic_reg: RTL and testbench
=======================================

Name: mq_iu_cu_elastic_reg

Overview:
Parametrised elastic pipeline register between the MQ coder interval-update (IU) and code-update (CU) stages. It carries the IU result bundle (shifted A, leading-zero count, C-select, Qe, CT-set, CT renorm value, coder-reset and flush markers). It adds valid/ready back-pressure through a 2-entry skid buffer, so the CU can stall without dropping symbols. It also provides an in-order kill and a saturating stall-cycle counter for performance analysis.

Parameters:
A_W, 16, width of shifted A register field
LZ_W, 4, width of leading-zero count field
QE_W, 16, width of Qe probability value field
CT_W, 4, width of CT renorm count field
STALL_W, 16, width of stall-cycle counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
kill  in  1  synchronous pipeline kill; discards all held entries
clr_stats  in  1  clears stall counter
in_valid  in  1  IU bundle valid
in_ready  out  1  register can accept bundle this cycle
in_a_shifted  in  A_W  shifted A value
in_lz  in  LZ_W  leading-zero count
in_csel  in  1  C-register select
in_qe  in  QE_W  Qe value
in_set_ct  in  1  set-CT request
in_ct_renorm  in  CT_W  CT renorm value
in_coder_rst  in  1  coder-reset marker travelling with bundle
in_flush  in  1  flush marker travelling with bundle
out_valid  out  1  CU bundle valid
out_ready  in  1  CU accepts bundle
out_a_shifted, out_lz, out_csel, out_qe, out_set_ct, out_ct_renorm, out_coder_rst, out_flush  out  (widths as inputs)  registered bundle to CU
occupancy  out  2  entries held (0..2)
stall_cycles  out  STALL_W  saturating count of stalled cycles

Behaviour:
- Bundle is the concatenation of all in_* data fields. Fields are never modified, only stored and forwarded in order.
- Storage: main register (drives out_*) and skid register. State: EMPTY, ONE, TWO. occupancy = 0/1/2 respectively.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- in_ready = (state != TWO). It is a pure decode of the state register, with no combinational path from out_ready.
- out_valid = (state != EMPTY).
- EMPTY: in_fire -> main <= in, go to ONE. Otherwise stay in EMPTY.
- ONE: in_fire & out_fire -> main <= in, stay in ONE (full-throughput pass, 1 cycle latency).
- ONE: in_fire & !out_ready -> skid <= in, go to TWO.
- ONE: !in_fire & out_fire -> go to EMPTY.
- ONE: otherwise hold.
- TWO: out_fire -> main <= skid, go to ONE. in_valid is ignored because in_ready = 0.
- TWO: otherwise hold; main and skid stay stable.
- Latency: in_fire in cycle N with the register empty gives out_valid = 1 with that data in cycle N+1.
- Ordering: strictly FIFO. Coder-reset and flush markers are delivered in order with their bundle, never early.
- out_* data is stable while out_valid & !out_ready. In EMPTY, out_* holds the last loaded value.
- kill: at the next edge state <= EMPTY. Any in_fire in the same cycle is discarded. The data registers are unchanged. kill has priority over every transition except rst.
- rst: at the next edge state <= EMPTY and main/skid <= 0. All out_* fields therefore read 0, out_valid = 0, in_ready = 1, occupancy = 0, stall_cycles = 0. rst has priority over kill, clr_stats and all handshakes. rst mid-transfer drops the held entries.
- stall_cycles: increments by 1 each cycle with out_valid & !out_ready. It saturates at all-ones and does not wrap.
- clr_stats sets stall_cycles to 0. If clr_stats coincides with a stall cycle, the result is 0 (clear wins).
- kill does not affect stall_cycles.

Test Plan:
- Reset then streaming: out_ready = 1, drive 4 bundles with in_a_shifted = 0x8000, 0x8001, 0x8002, 0x8003 back-to-back -> each appears 1 cycle later in order. in_ready stays 1, occupancy stays 1, stall_cycles = 0.
- Back-pressure: out_ready = 0, send A = 0x1111 then A = 0x2222 -> occupancy 2, in_ready = 0, out_a_shifted holds 0x1111. Then out_ready = 1 -> 0x1111 then 0x2222, in_ready returns to 1 after the first pop. stall_cycles equals the number of stalled cycles.
- Marker ordering: bundle with in_flush = 1, in_ct_renorm = 0xC sent while a prior bundle is stalled -> out_flush = 1 only with its own bundle, and out_ct_renorm = 0xC on the same cycle.
- Kill: in TWO with in_valid = 1, assert kill for 1 cycle -> next cycle out_valid = 0, occupancy = 0, in_ready = 1. The incoming bundle is not delivered.
- Saturation: STALL_W = 4, hold out_valid & !out_ready for 20 cycles -> stall_cycles = 15 and holds. clr_stats during a stall -> 0 next cycle.
- Reset mid-operation: assert rst in state TWO -> next cycle all out_* = 0, out_valid = 0, occupancy = 0, stall_cycles = 0. The first bundle after reset passes with 1-cycle latency.

Source files
------------

// File: rtl/mq_iu_cu_elastic_reg.sv
// Elastic register between the MQ coder IU and CU stages: a 2-entry skid buffer
// with valid/ready handshake, in-order kill and a saturating stall-cycle counter.
module mq_iu_cu_elastic_reg #(
    parameter int A_W     = 16,
    parameter int LZ_W    = 4,
    parameter int QE_W    = 16,
    parameter int CT_W    = 4,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               kill,
    input  logic               clr_stats,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_W-1:0]     in_a_shifted,
    input  logic [LZ_W-1:0]    in_lz,
    input  logic               in_csel,
    input  logic [QE_W-1:0]    in_qe,
    input  logic               in_set_ct,
    input  logic [CT_W-1:0]    in_ct_renorm,
    input  logic               in_coder_rst,
    input  logic               in_flush,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_W-1:0]     out_a_shifted,
    output logic [LZ_W-1:0]    out_lz,
    output logic               out_csel,
    output logic [QE_W-1:0]    out_qe,
    output logic               out_set_ct,
    output logic [CT_W-1:0]    out_ct_renorm,
    output logic               out_coder_rst,
    output logic               out_flush,

    output logic [1:0]         occupancy,
    output logic [STALL_W-1:0] stall_cycles
);

    localparam int BW = A_W + LZ_W + 1 + QE_W + 1 + CT_W + 1 + 1;

    // Encoding chosen so the state register doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             r_state;
    logic [BW-1:0]      r_main;
    logic [BW-1:0]      r_skid;
    logic [STALL_W-1:0] r_stall;

    logic [BW-1:0]      w_in_bundle;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_stall;
    logic               w_stall_sat;

    assign w_in_bundle = {in_a_shifted, in_lz, in_csel, in_qe,
                          in_set_ct, in_ct_renorm, in_coder_rst, in_flush};

    // Handshake flags decode only the state register; no out_ready -> in_ready path.
    assign in_ready  = (r_state != ST_TWO);
    assign out_valid = (r_state != ST_EMPTY);
    assign occupancy = r_state;

    assign w_in_fire   = in_valid & in_ready;
    assign w_out_fire  = out_valid & out_ready;
    assign w_stall     = out_valid & ~out_ready;
    assign w_stall_sat = &r_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (kill) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_main  <= w_in_bundle;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main <= w_in_bundle;
                    end else if (w_in_fire) begin
                        r_skid  <= w_in_bundle;
                        r_state <= ST_TWO;
                    end else if (w_out_fire) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_out_fire) begin
                        r_main  <= r_skid;
                        r_state <= ST_ONE;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            r_stall <= '0;
        end else if (w_stall && !w_stall_sat) begin
            r_stall <= r_stall + {{(STALL_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cycles = r_stall;

    assign {out_a_shifted, out_lz, out_csel, out_qe,
            out_set_ct, out_ct_renorm, out_coder_rst, out_flush} = r_main;

endmodule

// File: tb/tb_mq_iu_cu_elastic_reg.sv
// Directed bench for mq_iu_cu_elastic_reg: streaming, back-pressure, marker
// ordering, kill, counter saturation/clear and reset mid-operation.
module tb_mq_iu_cu_elastic_reg;

    localparam int A_W     = 16;
    localparam int LZ_W    = 4;
    localparam int QE_W    = 16;
    localparam int CT_W    = 4;
    localparam int STALL_W = 4;

    logic               clk = 1'b0;
    logic               rst, kill, clr_stats;
    logic               in_valid, in_ready;
    logic [A_W-1:0]     in_a_shifted;
    logic [LZ_W-1:0]    in_lz;
    logic               in_csel;
    logic [QE_W-1:0]    in_qe;
    logic               in_set_ct;
    logic [CT_W-1:0]    in_ct_renorm;
    logic               in_coder_rst, in_flush;
    logic               out_valid, out_ready;
    logic [A_W-1:0]     out_a_shifted;
    logic [LZ_W-1:0]    out_lz;
    logic               out_csel;
    logic [QE_W-1:0]    out_qe;
    logic               out_set_ct;
    logic [CT_W-1:0]    out_ct_renorm;
    logic               out_coder_rst, out_flush;
    logic [1:0]         occupancy;
    logic [STALL_W-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mq_iu_cu_elastic_reg #(
        .A_W(A_W), .LZ_W(LZ_W), .QE_W(QE_W), .CT_W(CT_W), .STALL_W(STALL_W)
    ) dut (
        .clk(clk), .rst(rst), .kill(kill), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a_shifted(in_a_shifted), .in_lz(in_lz), .in_csel(in_csel),
        .in_qe(in_qe), .in_set_ct(in_set_ct), .in_ct_renorm(in_ct_renorm),
        .in_coder_rst(in_coder_rst), .in_flush(in_flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a_shifted(out_a_shifted), .out_lz(out_lz), .out_csel(out_csel),
        .out_qe(out_qe), .out_set_ct(out_set_ct), .out_ct_renorm(out_ct_renorm),
        .out_coder_rst(out_coder_rst), .out_flush(out_flush),
        .occupancy(occupancy), .stall_cycles(stall_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [A_W-1:0] a);
        in_valid     = v;
        in_a_shifted = a;
        in_lz        = '0;
        in_csel      = 1'b0;
        in_qe        = '0;
        in_set_ct    = 1'b0;
        in_ct_renorm = '0;
        in_coder_rst = 1'b0;
        in_flush     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; kill = 1'b0; clr_stats = 1'b0; out_ready = 1'b0;
        drive(1'b1, 16'hFFFF);
        in_lz = 4'hF; in_qe = 16'hFFFF; in_flush = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_occ", occupancy, 0);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_out_a", out_a_shifted, 0);
        chk("rst_out_flush", out_flush, 0);
        rst = 1'b0;

        // Streaming at full throughput
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'h8000 + 16'(i));
            tick();
            chk($sformatf("stream_a%0d", i), out_a_shifted, 16'h8000 + i);
            chk($sformatf("stream_valid%0d", i), out_valid, 1);
            chk($sformatf("stream_rdy%0d", i), in_ready, 1);
            chk($sformatf("stream_occ%0d", i), occupancy, 1);
        end
        drive(1'b0, 16'h0);
        tick();
        chk("stream_drain_valid", out_valid, 0);
        chk("stream_hold_a", out_a_shifted, 16'h8003);
        chk("stream_stall", stall_cycles, 0);

        // Back-pressure into the skid entry
        out_ready = 1'b0;
        drive(1'b1, 16'h1111);
        tick();
        chk("bp_occ1", occupancy, 1);
        drive(1'b1, 16'h2222);
        tick();
        chk("bp_occ2", occupancy, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_a", out_a_shifted, 16'h1111);
        drive(1'b0, 16'h0);
        tick();
        chk("bp_hold_a", out_a_shifted, 16'h1111);
        chk("bp_stall2", stall_cycles, 2);
        out_ready = 1'b1;
        tick();
        chk("bp_pop1_a", out_a_shifted, 16'h2222);
        chk("bp_pop1_rdy", in_ready, 1);
        chk("bp_pop1_occ", occupancy, 1);
        tick();
        chk("bp_empty", out_valid, 0);
        chk("bp_stall_final", stall_cycles, 2);

        // Markers travel with their own bundle
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("clr_stall", stall_cycles, 0);
        out_ready = 1'b0;
        drive(1'b1, 16'h3333);
        in_ct_renorm = 4'h1;
        tick();
        drive(1'b1, 16'h4444);
        in_flush = 1'b1; in_ct_renorm = 4'hC; in_lz = 4'h5; in_csel = 1'b1;
        in_qe = 16'h5601; in_set_ct = 1'b1; in_coder_rst = 1'b1;
        tick();
        chk("mk_first_flush", out_flush, 0);
        chk("mk_first_ct", out_ct_renorm, 4'h1);
        chk("mk_first_crst", out_coder_rst, 0);
        drive(1'b0, 16'h0);
        out_ready = 1'b1;
        tick();
        chk("mk_a", out_a_shifted, 16'h4444);
        chk("mk_flush", out_flush, 1);
        chk("mk_ct", out_ct_renorm, 4'hC);
        chk("mk_lz", out_lz, 4'h5);
        chk("mk_csel", out_csel, 1);
        chk("mk_qe", out_qe, 16'h5601);
        chk("mk_set_ct", out_set_ct, 1);
        chk("mk_crst", out_coder_rst, 1);
        tick();
        chk("mk_empty", out_valid, 0);

        // Kill while full with a bundle offered
        out_ready = 1'b0;
        drive(1'b1, 16'hAAAA);
        tick();
        drive(1'b1, 16'hBBBB);
        tick();
        chk("kill_pre_occ", occupancy, 2);
        drive(1'b1, 16'hCCCC);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        chk("kill_valid", out_valid, 0);
        chk("kill_occ", occupancy, 0);
        chk("kill_rdy", in_ready, 1);
        chk("kill_data_kept", out_a_shifted, 16'hAAAA);
        drive(1'b0, 16'h0);
        out_ready = 1'b1;
        tick();
        chk("kill_no_deliver", out_valid, 0);

        // Stall counter saturation and clear
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 16'h5555);
        tick();
        drive(1'b0, 16'h0);
        repeat (20) tick();
        chk("sat_15", stall_cycles, 15);
        tick();
        chk("sat_hold", stall_cycles, 15);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("sat_clr", stall_cycles, 0);
        tick();
        chk("sat_resume", stall_cycles, 1);

        // Reset while full
        drive(1'b1, 16'h6666);
        tick();
        chk("rm_occ2", occupancy, 2);
        drive(1'b0, 16'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rm_valid", out_valid, 0);
        chk("rm_occ", occupancy, 0);
        chk("rm_rdy", in_ready, 1);
        chk("rm_stall", stall_cycles, 0);
        chk("rm_a", out_a_shifted, 0);
        chk("rm_ct", out_ct_renorm, 0);
        out_ready = 1'b1;
        drive(1'b1, 16'h7777);
        tick();
        chk("rm_post_valid", out_valid, 1);
        chk("rm_post_a", out_a_shifted, 16'h7777);
        drive(1'b0, 16'h0);
        tick();
        chk("rm_post_drain", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
